xy_pattern_driver: RTL and testbench

- Programmable stimulus source for the two-input (x,y) sequence-detector interface used by the chapter-5 state-machine blocks.
- Replays a loaded list of 2-bit {x,y} symbols, one per clock, into a detector, optionally looping.
- Counts rising edges of the detector's z output during a run, closing the loop for self-checking.

---
 rtl/xy_pattern_driver_pkg.sv | 21 ++
 rtl/xy_pattern_driver_if.sv | 33 +++
 rtl/xy_pattern_driver_sat_edge_counter.sv | 33 +++
 rtl/xy_pattern_driver.sv | 108 ++++++++++
 tb/tb_xy_pattern_driver.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/xy_pattern_driver_pkg.sv
// Shared definitions for the (x,y) pattern driver: state codes, symbol names
// and the length-field width helper.
package xy_pattern_driver_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_W     = $clog2(DEPTH_DEF + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] XY_00 = 2'b00;
  localparam logic [1:0] XY_01 = 2'b01;
  localparam logic [1:0] XY_10 = 2'b10;
  localparam logic [1:0] XY_11 = 2'b11;

  function automatic int calc_len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/xy_pattern_driver_if.sv
// Control, stimulus and feedback signals between a test controller (master)
// and the pattern driver (slave).
interface xy_pattern_driver_if
  import xy_pattern_driver_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic                           start;
  logic                           stop;
  logic                           loop;
  logic [calc_len_w(DEPTH)-1:0]   len;
  logic [2*DEPTH-1:0]             pattern;
  logic                           z;
  logic                           x;
  logic                           y;
  logic                           xy_valid;
  logic                           busy;
  logic                           done;
  logic [CNT_W-1:0]               hit_count;

  modport master (
    output start, stop, loop, len, pattern, z,
    input  x, y, xy_valid, busy, done, hit_count
  );

  modport slave (
    input  start, stop, loop, len, pattern, z,
    output x, y, xy_valid, busy, done, hit_count
  );

endinterface

// File: rtl/xy_pattern_driver_sat_edge_counter.sv
// Rising-edge detector feeding a saturating counter with synchronous clear
// and an enable that gates which edges are counted.
module sat_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [CNT_W-1:0] count
);

  logic d_q;
  logic rise;

  assign rise = d & ~d_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_q   <= 1'b0;
      count <= '0;
    end else begin
      d_q <= d;
      if (clr)
        count <= '0;
      else if (en && rise && !(&count))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/xy_pattern_driver.sv
// Replays a captured list of {x,y} symbols one per clock, optionally looping,
// and counts rising edges of the detector's z output during the run.
module xy_pattern_driver
  import xy_pattern_driver_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  xy_pattern_driver_if.slave  bus
);

  localparam int            LW      = calc_len_w(DEPTH);
  localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH);

  logic [0:0]         state;
  logic [LW-1:0]      index;
  logic [LW-1:0]      len_q;
  logic [2*DEPTH-1:0] pattern_q;
  logic               x_q;
  logic               y_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   hits;

  logic               accept;
  logic               last;
  logic [LW-1:0]      next_index;
  logic [1:0]         next_sym;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept     = (state == ST_IDLE) && bus.start && (bus.len != '0) && (bus.len <= MAX_LEN);
    last       = (index == len_q - 1'b1);
    next_index = index + 1'b1;
    next_sym   = XY_00;
    for (int i = 0; i < DEPTH; i++) begin
      if (next_index == LW'(i))
        next_sym = pattern_q[2*i +: 2];
    end
  end

  // NOTE: the shadow pattern/len are plain flops, not a RAM, so they reset with everything else.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      index      <= '0;
      len_q      <= '0;
      pattern_q  <= '0;
      {x_q, y_q} <= XY_00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_RUN;
            index      <= '0;
            len_q      <= bus.len;
            pattern_q  <= bus.pattern;
            {x_q, y_q} <= bus.pattern[1:0];
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          // stop outranks both wrap and completion
          if (bus.stop || (last && !bus.loop)) begin
            state      <= ST_IDLE;
            index      <= '0;
            {x_q, y_q} <= XY_00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= !bus.stop;
          end else if (!last) begin
            index      <= next_index;
            {x_q, y_q} <= next_sym;
          end else begin
            index      <= '0;
            {x_q, y_q} <= pattern_q[1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_edge_counter #(.CNT_W(CNT_W)) u_hits (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (accept),
    .en    (busy_q),
    .d     (bus.z),
    .count (hits)
  );

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.xy_valid  = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit_count = hits;

endmodule

// File: tb/tb_xy_pattern_driver.sv
// Directed bench for xy_pattern_driver: two instances (8-bit and 2-bit hit
// counters) share stimulus and are compared every cycle against a run model.
module tb_xy_pattern_driver;
  import xy_pattern_driver_pkg::*;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             stop;
  logic             loop;
  logic [LEN_W-1:0] len;
  logic [15:0]      pattern;
  logic             z;

  int n_vec = 0;
  int n_err = 0;

  xy_pattern_driver_if #(.DEPTH(8), .CNT_W(8)) bus8 ();
  xy_pattern_driver_if #(.DEPTH(8), .CNT_W(2)) bus2 ();

  assign bus8.start = start;   assign bus2.start = start;
  assign bus8.stop = stop;     assign bus2.stop = stop;
  assign bus8.loop = loop;     assign bus2.loop = loop;
  assign bus8.len = len;       assign bus2.len = len;
  assign bus8.pattern = pattern; assign bus2.pattern = pattern;
  assign bus8.z = z;           assign bus2.z = z;

  xy_pattern_driver #(.DEPTH(8), .CNT_W(8)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));
  xy_pattern_driver #(.DEPTH(8), .CNT_W(2)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Run model: is a run active, which symbol is shown, and how many z rises were seen.
  bit          m_run;
  int          m_pos;
  int          m_len;
  logic [15:0] m_pat;
  int          m_hits;
  logic        m_zq;
  logic        m_done;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_run = 0; m_pos = 0; m_len = 0; m_pat = '0;
      m_hits = 0; m_zq = 1'b0; m_done = 1'b0;
    end else begin
      if (m_run && z && !m_zq) m_hits++;
      m_zq   = z;
      m_done = 1'b0;
      if (m_run) begin
        if (stop) m_run = 0;
        else if (m_pos < m_len - 1) m_pos++;
        else if (loop) m_pos = 0;
        else begin m_run = 0; m_done = 1'b1; end
      end else if (start && len >= 1 && len <= 8) begin
        m_run = 1; m_pos = 0; m_len = int'(len); m_pat = pattern; m_hits = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input logic x, input logic y, input logic v,
                         input logic b, input logic d, input logic [31:0] hc, input int sat);
    logic [1:0] es;
    es = m_run ? 2'((m_pat >> (2 * m_pos)) & 16'h3) : 2'b00;
    check({tag, ".xy"},       32'({x, y}), 32'(es));
    check({tag, ".xy_valid"}, 32'(v), 32'(m_run));
    check({tag, ".busy"},     32'(b), 32'(m_run));
    check({tag, ".done"},     32'(d), 32'(m_done));
    check({tag, ".hit_count"}, hc, 32'((m_hits > sat) ? sat : m_hits));
  endtask

  always @(negedge clk) begin
    cmp_dut("d8", bus8.x, bus8.y, bus8.xy_valid, bus8.busy, bus8.done, 32'(bus8.hit_count), 255);
    cmp_dut("d2", bus2.x, bus2.y, bus2.xy_valid, bus2.busy, bus2.done, 32'(bus2.hit_count), 3);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start(input int l, input logic [15:0] p);
    start = 1'b1; len = LEN_W'(l); pattern = p;
    tick();
    start = 1'b0;
  endtask

  localparam logic [15:0] PA = 16'h003A;
  localparam logic [15:0] PB = {12'h000, XY_01, XY_11};
  localparam logic [15:0] P8 = {XY_01, XY_10, XY_11, XY_01, XY_00, XY_10, XY_01, XY_11};

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    len = '0; pattern = '0; z = 1'b0;
    tick(); tick();
    check("reset.busy", 32'(bus8.busy), 32'h0);
    check("reset.hit", 32'(bus8.hit_count), 32'h0);
    rstn = 1'b1;
    tick();

    // Single non-looping run: 10,10,11 then done
    pulse_start(3, PA);
    check("run.sym0", 32'({bus8.x, bus8.y}), 32'h2);
    tick(); tick();
    check("run.sym2", 32'({bus8.x, bus8.y}), 32'h3);
    tick();
    check("run.done", 32'(bus8.done), 32'h1);
    check("run.end_busy", 32'(bus8.busy), 32'h0);
    tick();

    // Looping run, then drop loop while symbol 0 is shown
    loop = 1'b1;
    pulse_start(3, PA);
    tick(); tick(); tick();
    check("loop.wrap", 32'({bus8.x, bus8.y, bus8.busy}), 32'h5);
    tick(); tick(); tick();
    loop = 1'b0;
    tick(); tick(); tick();
    check("loop.done", 32'(bus8.done), 32'h1);
    tick();

    // Abort on the third symbol
    pulse_start(8, P8);
    tick(); tick();
    check("abort.sym2", 32'({bus8.x, bus8.y}), 32'h2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("abort.state", 32'({bus8.xy_valid, bus8.busy, bus8.done}), 32'h0);
    tick();

    // Edge counting: z = 0,1,1,0,1 over a 5-symbol run
    pulse_start(5, P8);
    z = 1'b0; tick();
    z = 1'b1; tick();
    z = 1'b1; tick();
    z = 1'b0; tick();
    z = 1'b1; tick();
    z = 1'b0;
    check("edge.hit8", 32'(bus8.hit_count), 32'd2);
    check("edge.hit2", 32'(bus2.hit_count), 32'd2);
    tick();

    // New start clears the count; five z pulses saturate the 2-bit counter
    loop = 1'b1;
    pulse_start(8, P8);
    check("clear.hit", 32'(bus8.hit_count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      z = (i % 2 == 0);
      tick();
    end
    z = 1'b0;
    check("sat.hit8", 32'(bus8.hit_count), 32'd5);
    check("sat.hit2", 32'(bus2.hit_count), 32'd3);
    stop = 1'b1; loop = 1'b0;
    tick();
    stop = 1'b0;

    // Illegal lengths are ignored
    pulse_start(0, PA);
    check("len0.busy", 32'(bus8.busy), 32'h0);
    pulse_start(9, PA);
    check("len9.busy", 32'(bus8.busy), 32'h0);

    // start while busy ignored (also on last symbol); start in done cycle accepted
    pulse_start(3, PA);
    start = 1'b1; len = LEN_W'(5); pattern = 16'hFFFF;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; len = LEN_W'(2); pattern = PB;
    tick();
    check("ovl.done", 32'(bus8.done), 32'h1);
    tick();
    start = 1'b0;
    check("ovl.new_sym0", 32'({bus8.x, bus8.y, bus8.busy}), 32'h7);
    tick(); tick(); tick();

    // Asynchronous reset in the middle of a run
    loop = 1'b1;
    pulse_start(8, P8);
    z = 1'b1;
    tick();
    z = 1'b0;
    check("areset.pre_hit", 32'(bus8.hit_count), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("areset.xy", 32'({bus8.x, bus8.y, bus8.xy_valid, bus8.busy, bus8.done}), 32'h0);
    check("areset.hit", 32'(bus8.hit_count), 32'h0);
    tick();
    rstn = 1'b1; loop = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
